hazard_irq_ctrl: RTL and testbench

Central pipeline-sequencing controller for the five-stage MIPS core. Each cycle it decides the PC source and the stall and flush controls for the IF/ID and ID/EX pipeline registers. Inputs are branch/jump resolution, load-use hazards, undefined-instruction detection and the external interrupt line. It latches interrupts, takes them only at a safe point in user mode, redirects fetch to the kernel vectors, and blocks re-entry until the kernel bit has propagated.

---
 rtl/hazard_irq_ctrl_if.sv | 33 +++
 rtl/hazard_irq_ctrl.sv | 101 ++++++++++
 tb/tb_hazard_irq_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/hazard_irq_ctrl_if.sv
// Bundle between the pipeline and its sequencing controller: hazard and interrupt
// status going in, PC select and pipeline-register controls coming back.
interface hazard_irq_ctrl_if;
    logic       irq;
    logic       pc31_id;
    logic       id_flushed;
    logic       branch_taken_ex;
    logic       jump_id;
    logic       load_use_id;
    logic       undef_id;
    logic [2:0] pc_sel;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       epc_we;
    logic       irq_ack;
    logic       irq_pending;

    // Pipeline side
    modport master (
        output irq, pc31_id, id_flushed, branch_taken_ex, jump_id, load_use_id, undef_id,
        input  pc_sel, pc_write, if_id_write, if_id_flush, id_ex_flush, epc_we, irq_ack,
               irq_pending
    );

    // Controller side
    modport slave (
        input  irq, pc31_id, id_flushed, branch_taken_ex, jump_id, load_use_id, undef_id,
        output pc_sel, pc_write, if_id_write, if_id_flush, id_ex_flush, epc_we, irq_ack,
               irq_pending
    );
endinterface

// File: rtl/hazard_irq_ctrl.sv
// Five-stage pipeline sequencer: picks the PC source, stalls and flushes, and takes
// latched interrupts only at a safe user-mode point, with a re-entry guard window.
module hazard_irq_ctrl #(
    parameter int GUARD_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    hazard_irq_ctrl_if.slave bus
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_GUARD = 1'b1
    } state_t;

    localparam logic [3:0] GUARD_INIT = 4'(GUARD_CYCLES);

    state_t     state_reg;
    logic       pending_reg;
    logic [3:0] gcnt_reg;

    logic [2:0] pc_sel_c;
    logic       pc_write_c;
    logic       if_id_write_c;
    logic       if_id_flush_c;
    logic       id_ex_flush_c;
    logic       epc_we_c;
    logic       take_c;
    logic       exc_c;

    // First matching rule wins; everything is held at defaults while in reset.
    always_comb begin
        pc_sel_c      = 3'd0;
        pc_write_c    = 1'b1;
        if_id_write_c = 1'b1;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        epc_we_c      = 1'b0;
        take_c        = 1'b0;
        exc_c         = 1'b0;
        if (!reset) begin
            if (bus.branch_taken_ex) begin
                pc_sel_c      = 3'd1;
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
            end else if (bus.undef_id && !bus.id_flushed) begin
                exc_c         = 1'b1;
                pc_sel_c      = 3'd4;
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
                epc_we_c      = 1'b1;
            end else if (bus.load_use_id) begin
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                id_ex_flush_c = 1'b1;
            end else if (state_reg == ST_RUN && pending_reg && !bus.pc31_id && !bus.id_flushed) begin
                // ID holds a real user instruction, so its PC+4 is a valid return address
                take_c        = 1'b1;
                pc_sel_c      = 3'd3;
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
                epc_we_c      = 1'b1;
            end else if (bus.jump_id) begin
                pc_sel_c      = 3'd2;
                if_id_flush_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg <= 1'b0;
            state_reg   <= ST_RUN;
            gcnt_reg    <= 4'd0;
        end else begin
            if (take_c)
                pending_reg <= 1'b0;
            else if (bus.irq)
                pending_reg <= 1'b1;

            if (exc_c || take_c) begin
                state_reg <= ST_GUARD;
                gcnt_reg  <= GUARD_INIT;
            end else if (state_reg == ST_GUARD) begin
                gcnt_reg <= gcnt_reg - 4'd1;
                if (gcnt_reg == 4'd1)
                    state_reg <= ST_RUN;
            end
        end
    end

    assign bus.pc_sel      = pc_sel_c;
    assign bus.pc_write    = pc_write_c;
    assign bus.if_id_write = if_id_write_c;
    assign bus.if_id_flush = if_id_flush_c;
    assign bus.id_ex_flush = id_ex_flush_c;
    assign bus.epc_we      = epc_we_c;
    assign bus.irq_ack     = take_c;
    assign bus.irq_pending = pending_reg;

endmodule

// File: tb/tb_hazard_irq_ctrl.sv
// Directed bench for hazard_irq_ctrl: steps the pipeline inputs cycle by cycle and
// checks the control outputs and the pending flag against hand-computed values.
module tb_hazard_irq_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    hazard_irq_ctrl_if bus ();

    hazard_irq_ctrl #(.GUARD_CYCLES(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_sel, pc_write, if_id_write, if_id_flush, id_ex_flush, epc_we, irq_ack}
    localparam logic [8:0] O_DEF  = {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [8:0] O_BR   = {3'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic [8:0] O_JMP  = {3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [8:0] O_TAKE = {3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam logic [8:0] O_EXC  = {3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic [8:0] O_LU   = {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    function automatic logic [8:0] outs();
        return {bus.pc_sel, bus.pc_write, bus.if_id_write, bus.if_id_flush,
                bus.id_ex_flush, bus.epc_we, bus.irq_ack};
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Let inputs settle, compare outputs and pending, then advance one edge.
    task automatic step(input string tag, input logic [8:0] exp_o, input logic exp_p);
        #1;
        check({tag, ".out"}, outs(), exp_o);
        check({tag, ".pend"}, {8'd0, bus.irq_pending}, {8'd0, exp_p});
        $display("step %-14s out=%b pend=%b", tag, outs(), bus.irq_pending);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.irq = 1'b1;
        bus.pc31_id = 1'b0;
        bus.id_flushed = 1'b0;
        bus.branch_taken_ex = 1'b0;
        bus.jump_id = 1'b0;
        bus.load_use_id = 1'b0;
        bus.undef_id = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with irq high: defaults, nothing latched
        step("rst1", O_DEF, 1'b0);
        step("rst2", O_DEF, 1'b0);
        reset = 1'b0; bus.irq = 1'b0;
        step("rel", O_DEF, 1'b0);
        step("rel_idle", O_DEF, 1'b0);

        // Clean IRQ: one-cycle pulse, take next cycle, then a 3-cycle guard
        bus.irq = 1'b1;
        step("irq_rise", O_DEF, 1'b0);
        bus.irq = 1'b0;
        step("take1", O_TAKE, 1'b1);
        bus.irq = 1'b1;
        step("guard1", O_DEF, 1'b0);
        step("guard2", O_DEF, 1'b1);
        step("guard3", O_DEF, 1'b1);
        bus.irq = 1'b0;
        step("take2", O_TAKE, 1'b1);
        step("g_a", O_DEF, 1'b0);
        step("g_b", O_DEF, 1'b0);
        step("g_c", O_DEF, 1'b0);

        // Kernel mode masks the take; pending stays set
        bus.pc31_id = 1'b1; bus.irq = 1'b1;
        step("kern0", O_DEF, 1'b0);
        for (int i = 1; i < 20; i++) step("kern", O_DEF, 1'b1);
        bus.pc31_id = 1'b0; bus.irq = 1'b0;
        step("kern_take", O_TAKE, 1'b1);
        step("g_a", O_DEF, 1'b0);
        step("g_b", O_DEF, 1'b0);
        step("g_c", O_DEF, 1'b0);

        // Branch outranks undef, load-use and a pending IRQ; no guard is started
        bus.pc31_id = 1'b1; bus.irq = 1'b1;
        step("arm", O_DEF, 1'b0);
        bus.pc31_id = 1'b0; bus.irq = 1'b0;
        bus.branch_taken_ex = 1'b1; bus.undef_id = 1'b1; bus.load_use_id = 1'b1;
        step("prio", O_BR, 1'b1);
        bus.branch_taken_ex = 1'b0; bus.undef_id = 1'b0; bus.load_use_id = 1'b0;
        step("prio_take", O_TAKE, 1'b1);
        step("g_a", O_DEF, 1'b0);
        step("g_b", O_DEF, 1'b0);
        step("g_c", O_DEF, 1'b0);

        // Load-use stall delays the take by one cycle
        bus.pc31_id = 1'b1; bus.irq = 1'b1;
        step("arm", O_DEF, 1'b0);
        bus.pc31_id = 1'b0; bus.irq = 1'b0; bus.load_use_id = 1'b1;
        step("lu_stall", O_LU, 1'b1);
        bus.load_use_id = 1'b0;
        step("lu_take", O_TAKE, 1'b1);

        // Undef at guard cycle 2 restarts the guard for three more cycles
        step("ug1", O_DEF, 1'b0);
        bus.irq = 1'b1; bus.undef_id = 1'b1;
        step("ug_exc", O_EXC, 1'b0);
        bus.undef_id = 1'b0;
        step("ug_blk1", O_DEF, 1'b1);
        step("ug_blk2", O_DEF, 1'b1);
        step("ug_blk3", O_DEF, 1'b1);
        step("ug_take", O_TAKE, 1'b1);
        step("g_a", O_DEF, 1'b0);
        step("g_b", O_DEF, 1'b1);
        step("g_c", O_DEF, 1'b1);

        // Bubble in ID: no take, undef ignored
        bus.irq = 1'b0; bus.id_flushed = 1'b1; bus.undef_id = 1'b1;
        step("bubble", O_DEF, 1'b1);
        bus.id_flushed = 1'b0; bus.undef_id = 1'b0;
        step("bub_take", O_TAKE, 1'b1);

        // Reset mid-guard aborts the guard
        reset = 1'b1;
        step("rst_mid", O_DEF, 1'b0);
        reset = 1'b0; bus.irq = 1'b1;
        step("post_rst", O_DEF, 1'b0);
        bus.irq = 1'b0;
        step("rst_take", O_TAKE, 1'b1);

        // Undef in kernel mode still traps; jump redirects fetch
        bus.pc31_id = 1'b1; bus.undef_id = 1'b1;
        step("kern_undef", O_EXC, 1'b0);
        bus.pc31_id = 1'b0; bus.undef_id = 1'b0; bus.jump_id = 1'b1;
        step("jump", O_JMP, 1'b0);
        bus.jump_id = 1'b0;
        step("idle", O_DEF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
